// File: rtl/z80_ic_pkg.sv
// Shared constants and types for the Z80 IM2 interrupt controller.
package z80_ic_pkg;

    localparam logic [7:0] OPC_PREFIX_ED = 8'hED;
    localparam logic [7:0] OPC_RETI      = 8'h4D;
    localparam int         MAX_IRQ       = 8;
    localparam int         IDX_W         = $clog2(MAX_IRQ);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SAW_ED = 1'b1
    } reti_state_t;

endpackage

// File: rtl/z80_reti_detect.sv
// Watches opcode fetches on the Z80 bus and flags the ED 4D (RETI) sequence.
module z80_reti_detect
    import z80_ic_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic [7:0] di,
    output logic       reti_hit,
    output logic       reti_seen
);

    reti_state_t state_reg, state_next;
    logic [7:0]  opcode_reg;
    logic        captured_reg;
    logic        m1_prev_reg;
    logic        reti_seen_reg;
    logic        capture;
    logic        m1_rise;
    logic        evaluate;

    // INTA cycles never assert mreq_n, so they cannot capture an opcode.
    assign capture  = ~m1_n & ~mreq_n & ~rd_n;
    assign m1_rise  = m1_n & ~m1_prev_reg;
    assign evaluate = cen & m1_rise & captured_reg;

    always_comb begin
        state_next = state_reg;
        reti_hit   = 1'b0;
        if (evaluate) begin
            case (state_reg)
                IDLE: begin
                    if (opcode_reg == OPC_PREFIX_ED)
                        state_next = SAW_ED;
                end
                SAW_ED: begin
                    if (opcode_reg == OPC_RETI) begin
                        reti_hit   = 1'b1;
                        state_next = IDLE;
                    end else if (opcode_reg != OPC_PREFIX_ED) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            opcode_reg    <= 8'h00;
            captured_reg  <= 1'b0;
            m1_prev_reg   <= 1'b1;
            reti_seen_reg <= 1'b0;
        end else if (cen) begin
            m1_prev_reg   <= m1_n;
            state_reg     <= state_next;
            reti_seen_reg <= reti_hit;
            if (capture) begin
                opcode_reg   <= di;
                captured_reg <= 1'b1;
            end else if (m1_rise) begin
                captured_reg <= 1'b0;
            end
        end
    end

    assign reti_seen = reti_seen_reg;

endmodule

// File: rtl/z80_int_ctrl.sv
// Prioritised IM2 interrupt controller: request latching, nesting, vector
// supply during INTA and in-service release on RETI.
module z80_int_ctrl
    import z80_ic_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cen,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [7:0]         vec_base,
    input  logic               m1_n,
    input  logic               mreq_n,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic [7:0]         di,
    output logic               int_n,
    output logic [7:0]         vec_out,
    output logic               vec_oe,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               reti_seen
);

    logic [NUM_IRQ-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_IRQ-1:0] edge_prev_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
    logic               int_n_reg;
    logic [7:0]         vec_reg;
    logic               ack_prev_reg;

    logic [NUM_IRQ-1:0] synced;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] allow;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_IRQ-1:0] ack_set;
    logic [NUM_IRQ-1:0] reti_clr;
    logic               ack;
    logic               ack_start;
    logic               reti_hit;
    logic               unused_vec_low;

    assign unused_vec_low = ^vec_base[3:0];

    assign synced   = sync_reg[SYNC_STAGES-1];
    assign irq_edge = synced & ~edge_prev_reg;

    // A level is allowed only if no equal-or-higher level is in service.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_allow
            assign allow[gi] = ~|in_service_reg[gi:0];
        end
    endgenerate

    assign elig       = pending_reg & ~irq_mask & allow;
    assign win_onehot = elig & (-elig);

    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i])
                win_idx = IDX_W'(i);
        end
    end

    assign ack       = ~m1_n & ~iorq_n;
    assign ack_start = ack & ~ack_prev_reg;
    assign ack_set   = (ack_start && (|elig)) ? win_onehot : '0;
    assign reti_clr  = reti_hit ? (in_service_reg & (-in_service_reg)) : '0;

    assign pending_next    = (pending_reg & ~ack_set) | irq_edge;
    assign in_service_next = (in_service_reg | ack_set) & ~reti_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_reg[s] <= '0;
        end else if (cen) begin
            sync_reg[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_reg[s] <= sync_reg[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_prev_reg  <= '0;
            pending_reg    <= '0;
            in_service_reg <= '0;
            int_n_reg      <= 1'b1;
            vec_reg        <= 8'h00;
            ack_prev_reg   <= 1'b0;
        end else if (cen) begin
            edge_prev_reg  <= synced;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            int_n_reg      <= ~|elig;
            ack_prev_reg   <= ack;
            // Frozen through the acknowledge so the CPU reads a stable vector.
            if (!ack && (|elig))
                vec_reg <= {vec_base[7:4], win_idx, 1'b0};
        end
    end

    z80_reti_detect u_reti_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .cen       (cen),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .rd_n      (rd_n),
        .di        (di),
        .reti_hit  (reti_hit),
        .reti_seen (reti_seen)
    );

    assign int_n      = int_n_reg;
    assign vec_out    = vec_reg;
    assign vec_oe     = ack;
    assign in_service = in_service_reg;

endmodule
